// File: rtl/cic_comp_fir.sv
// 11-tap symmetric droop-compensation FIR for the CIC decimator output.
// One shared multiplier: the symmetric tap pairs are pre-added, then folded in over 6 MAC cycles.
module cic_comp_fir #(
    parameter int NIN   = 21,
    parameter int NOUT  = 16,
    parameter int NCOEF = 12,
    parameter int SHIFT = 9,
    parameter int NTAP  = 11
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   din_valid,
    input  logic signed [NIN-1:0]  din,
    output logic                   dout_valid,
    output logic signed [NOUT-1:0] dout,
    output logic                   busy,
    output logic                   ovf
);

    localparam int ACCW = NIN + NCOEF + 4;
    localparam int PRDW = NIN + NCOEF + 1;

    localparam logic signed [ACCW-1:0] RND  = ACCW'(1) <<< (SHIFT - 1);
    localparam logic signed [ACCW-1:0] OMAX = ACCW'((1 << (NOUT - 1)) - 1);
    localparam logic signed [ACCW-1:0] OMIN = -OMAX - ACCW'(1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MAC  = 2'd1,
        OUT  = 2'd2
    } state_t;

    state_t                   state;
    logic signed [NIN-1:0]    x [NTAP];
    logic signed [ACCW-1:0]   acc;
    logic [2:0]               idx;

    logic [3:0]               mirror;
    logic signed [NIN:0]      pre;
    logic signed [NCOEF-1:0]  coef;
    logic signed [PRDW-1:0]   prod;
    logic signed [ACCW-1:0]   rsum;
    logic signed [ACCW-1:0]   rshift;
    logic signed [ACCW-1:0]   sat;

    always_comb begin
        coef = NCOEF'(512);
        case (idx)
            3'd0:    coef = NCOEF'(-3);
            3'd1:    coef = NCOEF'(7);
            3'd2:    coef = NCOEF'(-16);
            3'd3:    coef = NCOEF'(36);
            3'd4:    coef = NCOEF'(-82);
            default: coef = NCOEF'(512);
        endcase
    end

    // Centre tap (idx 5) has no partner; every other step sums a mirrored pair.
    always_comb begin
        mirror = 4'd10 - {1'b0, idx};
        if (idx == 3'd5) begin
            pre = {x[5][NIN-1], x[5]};
        end else begin
            pre = {x[idx][NIN-1], x[idx]} + {x[mirror][NIN-1], x[mirror]};
        end
        prod = pre * coef;
    end

    always_comb begin
        rsum   = acc + RND;
        rshift = rsum >>> SHIFT;
        sat    = rshift;
        if (rshift > OMAX) begin
            sat = OMAX;
        end else if (rshift < OMIN) begin
            sat = OMIN;
        end
    end

    assign busy = (state != IDLE);

    // din_valid is a one-cycle strobe with no back-pressure: it is accepted only in IDLE,
    // otherwise the sample is dropped and ovf latches until reset.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state      <= IDLE;
            acc        <= '0;
            idx        <= '0;
            dout       <= '0;
            dout_valid <= 1'b0;
            ovf        <= 1'b0;
            for (int k = 0; k < NTAP; k++) begin
                x[k] <= '0;
            end
        end else begin
            dout_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (din_valid) begin
                        x[0] <= din;
                        for (int k = 1; k < NTAP; k++) begin
                            x[k] <= x[k-1];
                        end
                        acc   <= '0;
                        idx   <= '0;
                        state <= MAC;
                    end
                end
                MAC: begin
                    if (din_valid) begin
                        ovf <= 1'b1;
                    end
                    acc <= acc + ACCW'(prod);
                    if (idx == 3'd5) begin
                        state <= OUT;
                    end else begin
                        idx <= idx + 3'd1;
                    end
                end
                OUT: begin
                    if (din_valid) begin
                        ovf <= 1'b1;
                    end
                    dout       <= sat[NOUT-1:0];
                    dout_valid <= 1'b1;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cic_comp_fir.sv
// Directed bench for cic_comp_fir: impulse, DC, saturation, overrun and mid-operation reset.
module tb_cic_comp_fir;

    localparam int NIN  = 21;
    localparam int NOUT = 16;

    logic                   clk;
    logic                   rstn;
    logic                   din_valid;
    logic signed [NIN-1:0]  din;
    logic                   dout_valid;
    logic signed [NOUT-1:0] dout;
    logic                   busy;
    logic                   ovf;

    int n_checks = 0;
    int n_fail   = 0;

    int imp_exp [12] = '{-3, 7, -16, 36, -82, 512, -82, 36, -16, 7, -3, 0};

    cic_comp_fir dut (
        .clk        (clk),
        .rstn       (rstn),
        .din_valid  (din_valid),
        .din        (din),
        .dout_valid (dout_valid),
        .dout       (dout),
        .busy       (busy),
        .ovf        (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Strobe one sample, then wait (bounded) for its dout_valid.
    task automatic send(input int v, output int out, output int lat);
        din       = v[NIN-1:0];
        din_valid = 1'b1;
        @(posedge clk);
        #1;
        din_valid = 1'b0;
        din       = 21'h15555;
        lat = -1;
        out = 0;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk);
            #1;
            if (dout_valid) begin
                lat = i;
                out = dout;
                break;
            end
        end
        @(posedge clk);
        #1;
        chk("valid_one_cycle", int'(dout_valid), 0);
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic run_impulse(input string tag);
        int o, l;
        send(512, o, l);
        chk({tag, "_lat"}, l, 7);
        chk({tag, "_tap0"}, o, imp_exp[0]);
        for (int k = 1; k < 12; k++) begin
            send(0, o, l);
            chk({tag, "_lat"}, l, 7);
            chk($sformatf("%s_tap%0d", tag, k), o, imp_exp[k]);
        end
    endtask

    task automatic run_hold(input int v, input int n, input string tag, input int exp);
        int o, l;
        for (int k = 0; k < n; k++) begin
            send(v, o, l);
        end
        chk({tag, "_lat"}, l, 7);
        chk(tag, o, exp);
    endtask

    initial begin
        int o, l;
        int nvalid, first_c, second_c;
        int v1, v2;

        rstn      = 1'b0;
        din_valid = 1'b0;
        din       = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_dout", int'(dout), 0);
        chk("rst_dout_valid", int'(dout_valid), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_ovf", int'(ovf), 0);
        rstn = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        run_impulse("impulse");

        run_hold(1000, 11, "dc_1000", 773);
        run_hold(1000, 1, "dc_1000_hold", 773);

        run_hold(1048575, 11, "sat_pos", 32767);
        chk("sat_pos_ovf", int'(ovf), 0);
        run_hold(-1048576, 11, "sat_neg", -32768);
        chk("sat_neg_ovf", int'(ovf), 0);

        for (int k = 0; k < 11; k++) begin
            send(0, o, l);
        end
        chk("flush_zero", o, 0);

        // Strobes at cycles 0, 3 and 8: the second is dropped, the third is accepted.
        nvalid = 0; first_c = -1; second_c = -1; v1 = 0; v2 = 0;
        for (int c = 0; c < 24; c++) begin
            din_valid = (c == 0) || (c == 3) || (c == 8);
            din = (c == 0) ? 21'sd512 : (c == 3) ? 21'sd9999 : 21'sd0;
            if (c == 1) chk("busy_in_mac", int'(busy), 1);
            @(posedge clk);
            #1;
            din_valid = 1'b0;
            if (dout_valid) begin
                nvalid++;
                if (nvalid == 1) begin first_c = c; v1 = dout; end
                if (nvalid == 2) begin second_c = c; v2 = dout; end
            end
        end
        chk("ovr_num_valid", nvalid, 2);
        chk("ovr_first_cycle", first_c, 7);
        chk("ovr_first_val", v1, -3);
        chk("ovr_second_cycle", second_c, 15);
        chk("ovr_second_val", v2, 7);
        chk("ovr_flag", int'(ovf), 1);
        repeat (10) @(posedge clk);
        #1;
        chk("ovr_sticky", int'(ovf), 1);

        // Reset pulse while in MAC.
        din       = 21'sd512;
        din_valid = 1'b1;
        @(posedge clk);
        #1;
        din_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("pre_rst_busy", int'(busy), 1);
        rstn = 1'b0;
        #2;
        chk("midrst_dout", int'(dout), 0);
        chk("midrst_dout_valid", int'(dout_valid), 0);
        chk("midrst_busy", int'(busy), 0);
        chk("midrst_ovf", int'(ovf), 0);
        @(posedge clk);
        #1;
        rstn = 1'b1;
        nvalid = 0;
        for (int c = 0; c < 12; c++) begin
            @(posedge clk);
            #1;
            if (dout_valid) nvalid++;
        end
        chk("midrst_no_valid", nvalid, 0);

        run_impulse("impulse2");
        chk("final_ovf", int'(ovf), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
